// File: rtl/spi_target.sv
// SPI mode 0/2 target with a 16x8 register file, command-byte protocol and auto-incrementing pointer.
// SPI pins are oversampled on CLK; a local side port shares the register file.
module spi_target #(
    parameter bit       CPOL = 1'b0,
    parameter bit [7:0] ID   = 8'hA5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [3:0] LADDR,
    output logic [7:0] LRDATA,
    input  logic       LWE,
    input  logic [7:0] LWDATA,
    output logic       WSTB,
    output logic [3:0] WADDR,
    output logic       BUSY
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     state_r, state_next_s;
    logic [1:0] sck_sync_r, mosi_sync_r, nss_sync_r;
    logic       sck_d_r, nss_d_r, busy_r;
    logic       sck_s, lead_s, trail_s, nss_fall_s;
    logic [7:0] regs_r [16];
    logic [7:0] rx_r, tx_r, rx_next_s;
    logic [2:0] cnt_r;
    logic [3:0] ptr_r, waddr_r;
    logic       mode_r, byte_done_r, wstb_r;
    logic       start_s, abort_s, active_s, byte_end_s, cmd_done_s, commit_s;
    logic       reload_s, shift_out_s, shift_in_s;

    // Pin synchronizers and edge-detect delay flops; nSS resets low so a frame
    // already running at reset release never presents a falling edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sck_sync_r  <= {2{CPOL}};
            mosi_sync_r <= 2'b00;
            nss_sync_r  <= 2'b00;
            sck_d_r     <= 1'b0;
            nss_d_r     <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[0], SCK};
            mosi_sync_r <= {mosi_sync_r[0], MOSI};
            nss_sync_r  <= {nss_sync_r[0], nSS};
            sck_d_r     <= sck_s;
            nss_d_r     <= nss_sync_r[1];
        end
    end

    // SCK is normalised so that the leading edge is always a rising one
    assign sck_s      = sck_sync_r[1] ^ CPOL;
    assign lead_s     = sck_s & ~sck_d_r;
    assign trail_s    = ~sck_s & sck_d_r;
    assign nss_fall_s = nss_d_r & ~nss_sync_r[1];
    assign rx_next_s  = {rx_r[6:0], mosi_sync_r[1]};

    // State register and registered select-status outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (nss_fall_s) state_next_s = ST_CMD;
                else            state_next_s = ST_IDLE;
            end
            ST_CMD: begin
                if (nss_sync_r[1])                  state_next_s = ST_IDLE;
                else if (lead_s && cnt_r == 3'd7)   state_next_s = ST_DATA;
                else                                state_next_s = ST_CMD;
            end
            ST_DATA: begin
                if (nss_sync_r[1]) state_next_s = ST_IDLE;
                else               state_next_s = ST_DATA;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the shift datapath
    always_comb begin
        start_s  = 1'b0;
        abort_s  = 1'b0;
        active_s = 1'b0;
        case (state_r)
            ST_IDLE: start_s = nss_fall_s;
            ST_CMD, ST_DATA: begin
                if (nss_sync_r[1]) abort_s  = 1'b1;
                else               active_s = 1'b1;
            end
            default: abort_s = 1'b1;
        endcase
        shift_in_s  = active_s & lead_s;
        byte_end_s  = shift_in_s & (cnt_r == 3'd7);
        cmd_done_s  = byte_end_s & (state_r == ST_CMD);
        commit_s    = byte_end_s & (state_r == ST_DATA) & mode_r;
        reload_s    = active_s & trail_s & byte_done_r;
        shift_out_s = active_s & trail_s & ~byte_done_r;
    end

    // Shift registers, bit counter, pointer and mode
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_r        <= 8'h00;
            tx_r        <= 8'h00;
            cnt_r       <= 3'd0;
            ptr_r       <= 4'd0;
            mode_r      <= 1'b0;
            byte_done_r <= 1'b0;
        end else if (start_s) begin
            tx_r        <= ID;
            cnt_r       <= 3'd0;
            mode_r      <= 1'b0;
            byte_done_r <= 1'b0;
        end else if (abort_s) begin
            cnt_r       <= 3'd0;
            mode_r      <= 1'b0;
            byte_done_r <= 1'b0;
        end else begin
            if (shift_in_s) begin
                rx_r  <= rx_next_s;
                cnt_r <= cnt_r + 3'd1;
            end
            if (byte_end_s)    byte_done_r <= 1'b1;
            else if (reload_s) byte_done_r <= 1'b0;
            if (cmd_done_s) begin
                mode_r <= rx_next_s[7];
                ptr_r  <= rx_next_s[3:0];
            end else if (commit_s || (reload_s && !mode_r)) begin
                ptr_r <= ptr_r + 4'd1;
            end
            // Read data is snapshotted here; later local writes do not touch the byte in flight
            if (reload_s)         tx_r <= mode_r ? 8'h00 : regs_r[ptr_r];
            else if (shift_out_s) tx_r <= {tx_r[6:0], 1'b0};
        end
    end

    // Register file: an SPI commit beats a local write to the same address
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) regs_r[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (commit_s && ptr_r == 4'(i))    regs_r[i] <= rx_next_s;
                else if (LWE && LADDR == 4'(i))    regs_r[i] <= LWDATA;
            end
        end
    end

    // Write strobe and address of the last committed SPI write
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wstb_r  <= 1'b0;
            waddr_r <= 4'd0;
        end else begin
            wstb_r <= commit_s;
            if (commit_s) waddr_r <= ptr_r;
        end
    end

    assign MISO    = tx_r[7];
    assign MISO_OE = busy_r;
    assign BUSY    = busy_r;
    assign WSTB    = wstb_r;
    assign WADDR   = waddr_r;
    assign LRDATA  = regs_r[LADDR];

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench: a CPOL=0 and a CPOL=1 target see the same frames and are checked
// against a byte-level protocol model of the register file.
module tb_spi_target;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sck = 1'b0;
    logic       sck_inv;
    logic       mosi = 1'b0;
    logic       nss = 1'b1;
    logic       lwe = 1'b0;
    logic [3:0] laddr = 4'd0;
    logic [7:0] lwdata = 8'h00;
    logic [1:0] miso_w, oe_w, wstb_w, busy_w;
    logic [7:0] lrdata_w [2];
    logic [3:0] waddr_w [2];

    int errors = 0;
    int checks = 0;
    logic [7:0] mregs [16];
    logic [7:0] tx_q[$];
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    logic [7:0] exp_m[$];
    logic [3:0] wq0[$];
    logic [3:0] wq1[$];
    logic [3:0] exp_w[$];

    assign sck_inv = ~sck;

    always #5 clk = ~clk;

    spi_target #(.CPOL(1'b0), .ID(8'hA5)) dut0 (
        .CLK(clk), .RESET(rst), .SCK(sck), .MOSI(mosi), .nSS(nss),
        .MISO(miso_w[0]), .MISO_OE(oe_w[0]), .LADDR(laddr), .LRDATA(lrdata_w[0]),
        .LWE(lwe), .LWDATA(lwdata), .WSTB(wstb_w[0]), .WADDR(waddr_w[0]), .BUSY(busy_w[0])
    );

    spi_target #(.CPOL(1'b1), .ID(8'hA5)) dut1 (
        .CLK(clk), .RESET(rst), .SCK(sck_inv), .MOSI(mosi), .nSS(nss),
        .MISO(miso_w[1]), .MISO_OE(oe_w[1]), .LADDR(laddr), .LRDATA(lrdata_w[1]),
        .LWE(lwe), .LWDATA(lwdata), .WSTB(wstb_w[1]), .WADDR(waddr_w[1]), .BUSY(busy_w[1])
    );

    // Record every write strobe with its address
    always @(negedge clk) begin
        if (wstb_w[0]) wq0.push_back(waddr_w[0]);
        if (wstb_w[1]) wq1.push_back(waddr_w[1]);
    end

    // Protocol model: ID during the command byte, then 00 per written byte or the pointed register
    function automatic void model_frame();
        logic [3:0] p;
        logic       wr;
        exp_m.delete();
        exp_w.delete();
        exp_m.push_back(8'hA5);
        wr = tx_q[0][7];
        p  = tx_q[0][3:0];
        for (int k = 1; k < tx_q.size(); k++) begin
            if (wr) begin
                exp_m.push_back(8'h00);
                mregs[p] = tx_q[k];
                exp_w.push_back(p);
            end else begin
                exp_m.push_back(mregs[p]);
            end
            p = p + 4'd1;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int nbits, input bit coll);
        logic [7:0] r0, r1;
        r0 = 8'h00;
        r1 = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            repeat (HALF) @(negedge clk);
            r0[i] = miso_w[0];
            r1[i] = miso_w[1];
            sck = 1'b1;
            if (coll && i == 0) begin
                repeat (2) @(negedge clk);
                lwe = 1'b1;
                @(negedge clk);
                lwe = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b0;
        end
        if (nbits == 8) begin
            got0.push_back(r0);
            got1.push_back(r1);
        end
    endtask

    task automatic run_frame(input bit coll);
        got0.delete();
        got1.delete();
        wq0.delete();
        wq1.delete();
        nss = 1'b0;
        repeat (8) @(negedge clk);
        foreach (tx_q[k]) send_byte(tx_q[k], 8, coll && (k == tx_q.size() - 1));
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic local_write(input logic [3:0] a, input logic [7:0] d);
        laddr  = a;
        lwdata = d;
        lwe    = 1'b1;
        @(negedge clk);
        lwe    = 1'b0;
        mregs[a] = d;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 16; a++) mregs[a] = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (miso_w !== 2'b00 || oe_w !== 2'b00 || wstb_w !== 2'b00 || busy_w !== 2'b00) begin
            errors++;
            $display("FAIL rst_outputs: miso=%b oe=%b wstb=%b busy=%b required all 00", miso_w, oe_w, wstb_w, busy_w);
        end
        checks++;
        if (waddr_w[0] !== 4'd0 || waddr_w[1] !== 4'd0) begin
            errors++;
            $display("FAIL rst_waddr: got %h/%h required 0", waddr_w[0], waddr_w[1]);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            laddr = 4'(a);
            #1;
            checks++;
            if (lrdata_w[0] !== 8'h00 || lrdata_w[1] !== 8'h00) begin
                errors++;
                $display("FAIL rst_reg%0d: got %h/%h required 00", a, lrdata_w[0], lrdata_w[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_select();
        nss = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_w !== 2'b00) begin
            errors++;
            $display("FAIL sel_busy_early: got %b required 00", busy_w);
        end
        @(negedge clk);
        checks++;
        if (busy_w !== 2'b11 || oe_w !== 2'b11) begin
            errors++;
            $display("FAIL sel_busy_on: busy=%b oe=%b required 11", busy_w, oe_w);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (miso_w !== 2'b11 || busy_w !== 2'b11) begin
            errors++;
            $display("FAIL sel_hold_id7: miso=%b busy=%b required 11", miso_w, busy_w);
        end
        nss = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (oe_w !== 2'b11) begin
            errors++;
            $display("FAIL sel_oe_hold: got %b required 11", oe_w);
        end
        @(negedge clk);
        checks++;
        if (oe_w !== 2'b00 || busy_w !== 2'b00) begin
            errors++;
            $display("FAIL sel_oe_drop: oe=%b busy=%b required 00", oe_w, busy_w);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write_frame();
        tx_q = '{8'h83, 8'h5C, 8'hE1};
        model_frame();
        run_frame(1'b0);
        for (int k = 0; k < exp_m.size(); k++) begin
            checks++;
            if (got0[k] !== exp_m[k] || got1[k] !== exp_m[k]) begin
                errors++;
                $display("FAIL wr_miso byte%0d: got %h/%h required %h", k, got0[k], got1[k], exp_m[k]);
            end
        end
        checks++;
        if (wq0.size() != 2 || wq1.size() != 2 || wq0[0] !== 4'd3 || wq0[1] !== 4'd4
            || wq1[0] !== 4'd3 || wq1[1] !== 4'd4) begin
            errors++;
            $display("FAIL wr_wstb: counts %0d/%0d required 2 with addresses 3,4", wq0.size(), wq1.size());
        end
        for (int a = 3; a < 5; a++) begin
            laddr = 4'(a);
            #1;
            checks++;
            if (lrdata_w[0] !== mregs[a] || lrdata_w[1] !== mregs[a]) begin
                errors++;
                $display("FAIL wr_reg%0d: got %h/%h required %h", a, lrdata_w[0], lrdata_w[1], mregs[a]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_read_wrap();
        local_write(4'd15, 8'h11);
        local_write(4'd0, 8'h22);
        tx_q = '{8'h0F, 8'($urandom), 8'($urandom)};
        model_frame();
        run_frame(1'b0);
        for (int k = 0; k < exp_m.size(); k++) begin
            checks++;
            if (got0[k] !== exp_m[k] || got1[k] !== exp_m[k]) begin
                errors++;
                $display("FAIL rd_wrap byte%0d: got %h/%h required %h", k, got0[k], got1[k], exp_m[k]);
            end
        end
        checks++;
        if (wq0.size() != 0 || wq1.size() != 0) begin
            errors++;
            $display("FAIL rd_wrap_wstb: got %0d/%0d strobes required 0", wq0.size(), wq1.size());
        end
    endtask

    task automatic test_abort();
        local_write(4'd2, 8'h3C);
        got0.delete();
        got1.delete();
        wq0.delete();
        wq1.delete();
        nss = 1'b0;
        repeat (8) @(negedge clk);
        send_byte(8'h82, 8, 1'b0);
        send_byte(8'hF5, 5, 1'b0);
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (10) @(negedge clk);
        laddr = 4'd2;
        #1;
        checks++;
        if (lrdata_w[0] !== 8'h3C || lrdata_w[1] !== 8'h3C || wq0.size() != 0 || wq1.size() != 0) begin
            errors++;
            $display("FAIL abort_reg2: got %h/%h strobes %0d/%0d required 3c and 0",
                     lrdata_w[0], lrdata_w[1], wq0.size(), wq1.size());
        end
        @(negedge clk);
        tx_q = '{8'h02, 8'h00};
        model_frame();
        run_frame(1'b0);
        checks++;
        if (got0[1] !== 8'h3C || got1[1] !== 8'h3C) begin
            errors++;
            $display("FAIL abort_readback: got %h/%h required 3c", got0[1], got1[1]);
        end
    endtask

    task automatic test_collision();
        for (int r = 0; r < 2; r++) begin
            laddr  = (r == 0) ? 4'd7 : 4'd8;
            lwdata = 8'h44;
            mregs[laddr] = 8'h44;
            tx_q = '{8'h87, 8'h99};
            model_frame();
            run_frame(1'b1);
            for (int a = 7; a < 9; a++) begin
                laddr = 4'(a);
                #1;
                checks++;
                if (lrdata_w[0] !== mregs[a] || lrdata_w[1] !== mregs[a]) begin
                    errors++;
                    $display("FAIL coll%0d_reg%0d: got %h/%h required %h", r, a, lrdata_w[0], lrdata_w[1], mregs[a]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 1) == 1) local_write(4'($urandom_range(0, 15)), 8'($urandom));
            n = $urandom_range(1, 4);
            tx_q.delete();
            tx_q.push_back(8'($urandom));
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            model_frame();
            run_frame(1'b0);
            for (int k = 0; k < exp_m.size(); k++) begin
                checks++;
                if (got0[k] !== exp_m[k] || got1[k] !== exp_m[k]) begin
                    errors++;
                    $display("FAIL rand%0d_miso byte%0d cmd %h: got %h/%h required %h",
                             f, k, tx_q[0], got0[k], got1[k], exp_m[k]);
                end
            end
            checks++;
            if (wq0.size() != exp_w.size() || wq1.size() != exp_w.size()) begin
                errors++;
                $display("FAIL rand%0d_wstb: got %0d/%0d strobes required %0d", f, wq0.size(), wq1.size(), exp_w.size());
            end else begin
                for (int k = 0; k < exp_w.size(); k++) begin
                    checks++;
                    if (wq0[k] !== exp_w[k] || wq1[k] !== exp_w[k]) begin
                        errors++;
                        $display("FAIL rand%0d_waddr%0d: got %h/%h required %h", f, k, wq0[k], wq1[k], exp_w[k]);
                    end
                end
            end
        end
        for (int a = 0; a < 16; a++) begin
            laddr = 4'(a);
            #1;
            checks++;
            if (lrdata_w[0] !== mregs[a] || lrdata_w[1] !== mregs[a]) begin
                errors++;
                $display("FAIL rand_reg%0d: got %h/%h required %h", a, lrdata_w[0], lrdata_w[1], mregs[a]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        got0.delete();
        got1.delete();
        nss = 1'b0;
        repeat (8) @(negedge clk);
        send_byte(8'h85, 8, 1'b0);
        send_byte(8'hAB, 8, 1'b0);
        send_byte(8'hCD, 4, 1'b0);
        rst = 1'b1;
        for (int a = 0; a < 16; a++) mregs[a] = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_w !== 2'b00 || oe_w !== 2'b00 || miso_w !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_outputs: busy=%b oe=%b miso=%b required 00", busy_w, oe_w, miso_w);
        end
        rst = 1'b0;
        wq0.delete();
        wq1.delete();
        send_byte(8'h86, 8, 1'b0);
        send_byte(8'h77, 8, 1'b0);
        checks++;
        if (busy_w !== 2'b00 || wq0.size() != 0 || wq1.size() != 0) begin
            errors++;
            $display("FAIL rstmid_ignored: busy=%b strobes %0d/%0d required 00 and 0", busy_w, wq0.size(), wq1.size());
        end
        for (int a = 0; a < 16; a++) begin
            laddr = 4'(a);
            #1;
            checks++;
            if (lrdata_w[0] !== 8'h00 || lrdata_w[1] !== 8'h00) begin
                errors++;
                $display("FAIL rstmid_reg%0d: got %h/%h required 00", a, lrdata_w[0], lrdata_w[1]);
            end
        end
        @(negedge clk);
        nss = 1'b1;
        repeat (8) @(negedge clk);
        tx_q = '{8'h81, 8'h3C};
        model_frame();
        run_frame(1'b0);
        laddr = 4'd1;
        #1;
        checks++;
        if (lrdata_w[0] !== 8'h3C || lrdata_w[1] !== 8'h3C || got0[0] !== 8'hA5 || got1[0] !== 8'hA5) begin
            errors++;
            $display("FAIL rstmid_newframe: reg1 %h/%h id %h/%h required 3c and a5",
                     lrdata_w[0], lrdata_w[1], got0[0], got1[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_select();
        test_write_frame();
        test_read_wrap();
        test_abort();
        test_collision();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
